// File: rtl/rx_dll_lock_seq.sv
// RX DLL lock sequencer: request, timeout, settle qualification,
// retry and done/fail reporting in the clkp domain.
module rx_dll_lock_seq #(
  parameter int TMO_W      = 12,
  parameter int SETTLE_CYC = 16,
  parameter int MAX_RETRY  = 3,
  parameter int DROP_CYC   = 4
) (
  input  logic             clkp,
  input  logic             rstb_sync,
  input  logic             cal_start,
  input  logic             ms_nsl,
  input  logic [TMO_W-1:0] tmo_cfg,
  output logic             ms_rx_dll_lock_req,
  output logic             sl_rx_dll_lock_req,
  input  logic             ms_rx_dll_lock,
  input  logic             sl_rx_dll_lock,
  output logic             cal_done,
  output logic             cal_fail,
  output logic             lock_lost,
  output logic [2:0]       retry_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int DW = $clog2(DROP_CYC + 1);

  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYC);
  localparam logic [DW-1:0] DRP_END = DW'(DROP_CYC - 1);
  localparam logic [2:0]    RTY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SETTLE,
    S_DONE,
    S_DROP,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SW-1:0]    set_q, set_d;
  logic [DW-1:0]    drp_q, drp_d;
  logic [2:0]       rty_q, rty_d;
  logic             side_q, side_d;
  logic             fd_q, fd_d;
  logic             ms_q, ms_d;
  logic             sl_q, sl_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             lost_q, lost_d;

  logic             lock;
  logic             req_d;
  logic [SW-1:0]    set_inc;
  logic             tmo_hit;

  assign lock = side_q ? ms_rx_dll_lock
                       : sl_rx_dll_lock;

  assign set_inc = (set_q == SET_MAX) ? set_q
                 : set_q + SW'(1);

  assign tmo_hit = (tmo_cfg != '0) &&
                   (tmo_q == tmo_cfg - TMO_W'(1));

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    set_d   = set_q;
    drp_d   = drp_q;
    rty_d   = rty_q;
    side_d  = side_q;
    fd_d    = fd_q;
    done_d  = done_q;
    fail_d  = fail_q;
    lost_d  = 1'b0;
    if (!cal_start) begin
      state_d = S_IDLE;
      rty_d   = '0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      fd_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          side_d  = ms_nsl;
          rty_d   = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          fd_d    = 1'b0;
        end
        S_REQ: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
          // Lock beats a coincident timeout.
          if (lock) begin
            set_d = SW'(1);
            if (SETTLE_CYC == 1) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_SETTLE;
            end
          end else if (tmo_hit) begin
            state_d = S_DROP;
            drp_d   = '0;
            fd_d    = 1'b0;
          end
        end
        S_SETTLE: begin
          if (lock) begin
            set_d = set_inc;
            if (set_inc == SET_MAX) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_DROP;
            drp_d   = '0;
            fd_d    = 1'b0;
          end
        end
        S_DONE: begin
          if (!lock) begin
            state_d = S_DROP;
            drp_d   = '0;
            fd_d    = 1'b1;
            done_d  = 1'b0;
            lost_d  = 1'b1;
            rty_d   = '0;
          end
        end
        S_DROP: begin
          if (drp_q < DRP_END) begin
            drp_d = drp_q + DW'(1);
          end else if (!lock) begin
            if (fd_q || rty_q < RTY_MAX) begin
              if (!fd_q && rty_q != 3'd7)
                rty_d = rty_q + 3'd1;
              fd_d    = 1'b0;
              state_d = S_REQ;
            end else begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
            end
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    req_d = (state_d == S_WAIT)   ||
            (state_d == S_SETTLE) ||
            (state_d == S_DONE);
    ms_d  = req_d &  side_d;
    sl_d  = req_d & ~side_d;
  end

  always_ff @(posedge clkp or negedge rstb_sync) begin
    if (!rstb_sync) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      set_q   <= '0;
      drp_q   <= '0;
      rty_q   <= '0;
      side_q  <= 1'b0;
      fd_q    <= 1'b0;
      ms_q    <= 1'b0;
      sl_q    <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      set_q   <= set_d;
      drp_q   <= drp_d;
      rty_q   <= rty_d;
      side_q  <= side_d;
      fd_q    <= fd_d;
      ms_q    <= ms_d;
      sl_q    <= sl_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      lost_q  <= lost_d;
    end
  end

  assign ms_rx_dll_lock_req = ms_q;
  assign sl_rx_dll_lock_req = sl_q;
  assign cal_done           = done_q;
  assign cal_fail           = fail_q;
  assign lock_lost          = lost_q;
  assign retry_cnt          = rty_q;

endmodule
